tick_serial_tx: RTL and testbench



---
 rtl/tick_serial_tx.sv | 163 ++++++++++++++++
 tb/tb_tick_serial_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_serial_tx.sv
// tick_serial_tx: UART-style serial transmitter paced by an external tick strobe.
// One bit period equals one tick interval. Frame: start bit, DATA_WIDTH data
// bits LSB first, optional even parity, STOP_BITS stop bits. tx is registered.
// Optional feature: define TICK_SERIAL_TX_PARITY_EN to insert the even-parity bit.
module tick_serial_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid,
    output logic                  ready,
    output logic                  tx,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP_IDX = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
`ifdef TICK_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tx_q, tx_d;
`ifdef TICK_SERIAL_TX_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    // Handshake and status are pure functions of the state register.
    assign ready = (state_q == IDLE);
    assign busy  = (state_q != IDLE);
    assign tx    = tx_q;

    // Next-state logic: every transition after acceptance waits for a sampled tick.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        shift_nxt = shift_q >> 1;
`ifdef TICK_SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick in this same cycle is deliberately ignored; the frame
                // aligns to the next tick seen in ARMED.
                if (valid) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    state_d = ARMED;
`ifdef TICK_SERIAL_TX_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end

            ARMED: begin
                if (tick) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (tick) begin
                    shift_d = shift_nxt;
                    if (cnt_q == LAST_DATA_IDX) begin
                        // Counter is reused to count stop bits, so clear it here.
                        cnt_d = '0;
`ifdef TICK_SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        tx_d  = shift_nxt[0];
                    end
                end
            end

`ifdef TICK_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            end
`endif

            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (cnt_q == LAST_STOP_IDX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
`ifdef TICK_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
`ifdef TICK_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_tick_serial_tx.sv
// tb_tick_serial_tx: scoreboard bench for tick_serial_tx. Two instances share
// clk, rst and a period-4 tick: dut_a has one stop bit, dut_b has two.
// A monitor per instance decodes each frame clock by clock against the queue.
module tb_tick_serial_tx;

    localparam int TP = 4;
    localparam int DW = 8;
`ifdef TICK_SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          valid_a = 1'b0, valid_b = 1'b0;
    logic          ready_a, tx_a, busy_a;
    logic          ready_b, tx_b, busy_b;

    tick_serial_tx #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_a), .valid(valid_a),
        .ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    tick_serial_tx #(.DATA_WIDTH(DW), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .data_in(data_b), .valid(valid_b),
        .ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Tick strobe: one clock high every TP clocks, changed on the falling edge.
    initial begin
        int tick_cnt;
        tick_cnt = 0;
        forever begin
            @(negedge clk);
            tick_cnt = (tick_cnt == TP - 1) ? 0 : tick_cnt + 1;
            tick     = (tick_cnt == 0);
        end
    end

    int   cyc = 0;
    logic tick_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        tick_at_edge <= tick;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic txv(input int w);
        return (w == 0) ? tx_a : tx_b;
    endfunction
    function automatic logic rdy(input int w);
        return (w == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic bsy(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    int frames_done[2] = '{0, 0};
    int last_start[2]  = '{0, 0};
    int last_end[2]    = '{0, 0};
    int last_gap[2]    = '{0, 0};
    bit mon_abort      = 1'b0;

    // Frame monitor: on a start bit, pop the expected word and check every
    // clock of every bit, then the ready/busy release one cycle after the end.
    task automatic monitor(input int w);
        int            sb;
        int            nb;
        logic [15:0]   exp_bits;
        logic [DW-1:0] d;
        bit            aborted;
        sb = (w == 0) ? 1 : 2;
        nb = 1 + DW + PAR + sb;
        forever begin
            @(negedge clk);
            if (txv(w) === 1'b0 && !mon_abort) begin
                check("start_on_tick", tick_at_edge, 1);
                last_gap[w]   = cyc - last_end[w];
                last_start[w] = cyc;
                d = '0;
                if (w == 0) begin
                    if (q_a.size() == 0) check("unexpected_frame_a", 1, 0);
                    else d = q_a.pop_front();
                end else begin
                    if (q_b.size() == 0) check("unexpected_frame_b", 1, 0);
                    else d = q_b.pop_front();
                end
                exp_bits    = '1;
                exp_bits[0] = 1'b0;
                for (int i = 0; i < DW; i++) exp_bits[1 + i] = d[i];
                if (PAR != 0) exp_bits[1 + DW] = ^d;
                aborted = 1'b0;
                for (int i = 0; i < nb && !aborted; i++) begin
                    for (int c = 0; c < TP && !aborted; c++) begin
                        if (i != 0 || c != 0) @(negedge clk);
                        if (mon_abort) aborted = 1'b1;
                        else begin
                            check("tx_bit", txv(w), exp_bits[i]);
                            check("ready_low", rdy(w), 0);
                        end
                    end
                end
                if (!aborted) begin
                    @(negedge clk);
                    check("ready_after_stop", rdy(w), 1);
                    check("busy_after_stop", bsy(w), 0);
                    last_end[w] = cyc;
                    frames_done[w]++;
                end
            end
        end
    endtask

    // Offer one word once the block is ready, then drop valid.
    task automatic send(input int w, input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy(w) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        if (w == 0) begin
            valid_a = 1'b1; data_a = d; q_a.push_back(d);
        end else begin
            valid_b = 1'b1; data_b = d; q_b.push_back(d);
        end
        @(posedge clk);
        @(negedge clk);
        if (w == 0) valid_a = 1'b0;
        else valid_b = 1'b0;
    endtask

    task automatic wait_frames(input int w, input int target);
        int n;
        n = 0;
        while (frames_done[w] < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("frame_count", frames_done[w], target);
    endtask

    initial begin
        int n;
        int hs;
        fork
            monitor(0);
            monitor(1);
        join_none

        // Reset, then a long idle stretch with ticks running.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_a", tx_a, 1);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_tx_b", tx_b, 1);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", tx_a, 1);
            check("idle_ready", ready_a, 1);
            check("idle_busy", busy_a, 0);
            check("idle_tx_b", tx_b, 1);
        end

        // Plain frames; parity (when built in) is 0 for 0xA5 and 1 for 0x07.
        send(0, 8'hA5);
        wait_frames(0, 1);
        send(0, 8'h07);
        wait_frames(0, 2);

        // Handshake on the same edge that samples a tick.
        n = 0;
        @(negedge clk);
        #1;
        while (tick !== 1'b1 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tick_align", tick, 1);
        valid_a = 1'b1;
        data_a  = 8'h5A;
        q_a.push_back(8'h5A);
        @(posedge clk);
        @(negedge clk);
        hs = cyc;
        check("ready_drop", ready_a, 0);
        data_a = 8'hFF;  // still valid, must be ignored while busy
        repeat (20) @(negedge clk);
        valid_a = 1'b0;
        wait_frames(0, 3);
        check("coincident_latency", last_start[0] - hs, TP);
        repeat (3 * TP) @(negedge clk);
        check("no_extra_frame", frames_done[0], 3);
        check("idle_after_ignored", tx_a, 1);

        // Reset during data bit 3 of 0x3C aborts the frame.
        send(0, 8'h3C);
        n = 0;
        while (tx_a !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_start_seen", tx_a, 0);
        repeat (4 * TP + 1) @(negedge clk);
        mon_abort = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", tx_a, 1);
        check("abort_ready", ready_a, 1);
        check("abort_busy", busy_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_abort = 1'b0;
        check("abort_no_frame", frames_done[0], 3);
        send(0, 8'h55);
        wait_frames(0, 4);

        // Two stop bits, back-to-back words with valid held high.
        @(negedge clk);
        valid_b = 1'b1;
        data_b  = 8'h00;
        q_b.push_back(8'h00);
        @(posedge clk);
        @(negedge clk);
        data_b = 8'hFF;
        q_b.push_back(8'hFF);
        n = 0;
        while (!ready_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("b2b_ready_rise", ready_b, 1);
        @(posedge clk);
        @(negedge clk);
        valid_b = 1'b0;
        wait_frames(1, 2);
        check("b2b_gap", last_gap[1], TP);
        check("b2b_queue_empty", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
